sass_receiver: RTL and testbench

- Single-wire SASS serial receiver: deserialises one frame from line `s` into a parallel word.
- Frame format:
  - idle high;
  - start bit 0;
  - DATA_L data bits, LSB first;
  - end bit 0;
  - line returns high.
- Every bit lasts T_D clock cycles. Sits at the receive end of a SASS link, paired with the SASS transmitter.

---
 rtl/sass_receiver.sv | 151 +++++++++++++++
 tb/tb_sass_receiver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sass_receiver.sv
// SASS single-wire serial receiver: start 0, DATA_L bits LSB first, end 0, idle high.
// Optional macro SASS_R_FERR_EN adds a `ferr` pulse for framing errors and rejected glitches.
module sass_receiver #(
    parameter int DATA_L = 8,
    parameter int T      = 300,
    parameter int CLK_F  = 50_000_000,
    parameter int RANGE  = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s,
    output logic              avl,
    output logic [DATA_L-1:0] data
`ifdef SASS_R_FERR_EN
    ,
    output logic              ferr
`endif
);

    // 5e7 * 300 does not fit in 32 bits, so the bit time is derived in 64-bit arithmetic.
    localparam longint unsigned T_D64 = (64'(CLK_F) * 64'(T)) / 64'(RANGE);
    localparam int T_D = int'(T_D64);
    localparam int CW  = $clog2(T_D);
    localparam int IW  = (DATA_L > 1) ? $clog2(DATA_L) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(T_D / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(T_D - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_L - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    state_t              state_q, state_d;
    logic                sync_q, ss_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DATA_L-1:0]   shift_q, shift_d;
    logic [DATA_L-1:0]   data_q, data_d;
    logic                avl_q, avl_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 1'b1;
            ss_q    <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            avl_q   <= 1'b0;
        end else begin
            sync_q  <= s;
            ss_q    <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            avl_q   <= avl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        avl_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!ss_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            // Half a bit later the start bit must still be low, otherwise it was a glitch.
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!ss_q) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = ss_q;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_HI;
                    if (!ss_q) begin
                        data_d = shift_q;
                        avl_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // The low tail of the end bit must not be mistaken for a new start bit.
            S_WAIT_HI: begin
                if (ss_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign avl  = avl_q;
    assign data = data_q;

`ifdef SASS_R_FERR_EN
    logic ferr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= ss_q && (((state_q == S_START) && (cnt_q == HALF_LAST)) ||
                               ((state_q == S_STOP)  && (cnt_q == BIT_LAST)));
        end
    end

    assign ferr = ferr_q;
`endif

endmodule

// File: tb/tb_sass_receiver.sv
// Directed bench for sass_receiver: event scoreboard predicts avl/data (and ferr) every cycle
// from the frame timing rules, plus literal checks after each scenario.
module tb_sass_receiver;
    localparam int DATA_L = 8;
    localparam int T      = 2;
    localparam int CLK_F  = 50_000_000;
    localparam int RANGE  = 1_000_000;
    localparam int T_D    = 100;
    // Output latency from the first edge that sees the falling start bit.
    localparam int LAT    = 2 + T_D / 2 + T_D * (DATA_L + 1);
    localparam int GLAT   = 2 + T_D / 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s   = 1'b1;
    logic              avl;
    logic [DATA_L-1:0] data;
`ifdef SASS_R_FERR_EN
    logic              ferr;
`endif

    sass_receiver #(
        .DATA_L(DATA_L),
        .T     (T),
        .CLK_F (CLK_F),
        .RANGE (RANGE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .s   (s),
        .avl (avl),
        .data(data)
`ifdef SASS_R_FERR_EN
        ,
        .ferr(ferr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        longint            t;
        logic [DATA_L-1:0] v;
        bit                fe;
    } ev_t;

    ev_t               evq[$];
    longint            ecount   = 0;
    int                checks   = 0;
    int                failures = 0;
    int                npulse   = 0;
    logic [DATA_L-1:0] exp_data = '0;
    bit                rst_s;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, ecount, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit ea;
        bit ef;
        ecount = ecount + 1;
        rst_s  = rst;
        #1;
        ea = 1'b0;
        ef = 1'b0;
        if (rst_s) begin
            exp_data = '0;
            evq.delete();
        end else if (evq.size() > 0 && evq[0].t == ecount) begin
            if (evq[0].fe) begin
                ef = 1'b1;
            end else begin
                ea       = 1'b1;
                exp_data = evq[0].v;
            end
            void'(evq.pop_front());
        end
        chk("avl", avl, ea);
        chk("data", data, exp_data);
`ifdef SASS_R_FERR_EN
        chk("ferr", ferr, ef);
`endif
        if (avl === 1'b1) npulse++;
    end

    task automatic idle(input int n);
        s = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [DATA_L-1:0] v, input logic eb, input int rst_bit,
                         input int hold_low);
        ev_t e;
        e.t  = ecount + 1 + LAT;
        e.v  = v;
        e.fe = eb;
        evq.push_back(e);
        s = 1'b0;
        repeat (T_D) @(negedge clk);
        for (int i = 0; i < DATA_L; i++) begin
            s = v[i];
            if (i == rst_bit) begin
                repeat (T_D / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                s   = 1'b1;
                return;
            end
            repeat (T_D) @(negedge clk);
        end
        s = eb;
        repeat (T_D) @(negedge clk);
        if (hold_low > 0) begin
            s = 1'b0;
            repeat (hold_low) @(negedge clk);
        end
        s = 1'b1;
    endtask

    task automatic glitch(input int n);
        ev_t e;
        e.t  = ecount + 1 + GLAT;
        e.v  = '0;
        e.fe = 1'b1;
        evq.push_back(e);
        s = 1'b0;
        repeat (n) @(negedge clk);
        s = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        s   = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_avl", avl, 0);
        chk("reset_data", data, 0);
        rst = 1'b0;
        idle(T_D);

        frame(8'd135, 1'b0, -1, 0);
        idle(T_D);
        chk("lit_135", data, 8'd135);

        frame(8'd95, 1'b0, -1, 0);
        idle(T_D);
        chk("lit_95", data, 8'd95);
        frame(8'd5, 1'b0, -1, 0);
        idle(T_D);
        frame(8'd200, 1'b0, -1, 0);
        idle(T_D);
        chk("lit_200", data, 8'd200);
        frame(8'd69, 1'b0, -1, 0);
        idle(T_D);
        chk("lit_69", data, 8'd69);
        chk("pulses_5", npulse, 5);

        glitch(30);
        idle(2 * T_D);
        chk("glitch_data", data, 8'd69);
        chk("glitch_pulses", npulse, 5);

        frame(8'd200, 1'b1, -1, 0);
        idle(T_D);
        chk("ferr_data", data, 8'd69);
        chk("ferr_pulses", npulse, 5);

        frame(8'd95, 1'b0, 4, 0);
        chk("rst_data", data, 0);
        idle(T_D);
        frame(8'd5, 1'b0, -1, 0);
        idle(T_D);
        chk("after_rst_5", data, 8'd5);
        chk("after_rst_pulses", npulse, 6);

        frame(8'd170, 1'b0, -1, 3 * T_D);
        idle(T_D);
        chk("hold_data", data, 8'd170);
        chk("hold_pulses", npulse, 7);
        frame(8'd85, 1'b0, -1, 0);
        idle(T_D);
        chk("final_data", data, 8'd85);
        chk("final_pulses", npulse, 8);

        chk("queue_drained", evq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
